pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Parametrised successor to the pipeline's single-register program counter.
- Holds the fetch PC and selects the next PC from sequential increment, branch/jump redirect and exception entry.
- Adds a one-entry pending-redirect buffer for redirects that arrive during a stall, plus a valid/ready fetch handshake to instruction memory.
- Flags misaligned redirect targets and vectors them to the exception entry. Sits between the hazard unit, the EX-stage branch resolver and IMEM.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- INST_BYTES, 4, sequential increment; power of two; alignment = log2(INST_BYTES) low bits zero.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit hold; the PC does not advance.
- redir_valid  in  1  branch/jump redirect request, single-cycle pulse.
- redir_target  in  ADDR_W  redirect target.
- exc_req  in  1  exception entry request, single-cycle pulse.
- imem_ready  in  1  IMEM accepts the current fetch.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- pend_valid  out  1  a redirect is buffered.
- misalign_err  out  1  one-cycle pulse: misaligned redirect was taken.
- bad_addr  out  ADDR_W  last misaligned target captured.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, pc_valid=0, pend_valid=0, misalign_err=0, bad_addr=0.
  - State=BOOT.
- States:
  - BOOT: one falling edge after reset deasserts, go to RUN with pc_valid=1. pc stays RESET_PC.
  - RUN: pc_valid=1.
  - There is no other state. Pending-buffer state is held in pend_valid plus a pend_target register.
- Accept (RUN): accept = pc_valid & imem_ready & ~stall. Only one next-PC source applies per edge.
- Next-PC priority at each falling edge, highest first:
  1. exc_req: pc<=EXC_VECTOR. Overrides stall and imem_ready. Clears pend_valid.
  2. redir_valid with misaligned target (low bits ≠0):
     - pc<=EXC_VECTOR, bad_addr<=redir_target, misalign_err=1 for one cycle.
     - Overrides stall. Clears pend_valid.
  3. redir_valid, aligned, and ~stall: pc<=redir_target. Does not wait for imem_ready; the current fetch is discarded.
  4. redir_valid, aligned, and stall:
     - pend_target<=redir_target, pend_valid<=1.
     - A newer redirect overwrites the pending one.
     - pc holds.
  5. pend_valid and ~stall: pc<=pend_target, pend_valid<=0.
  6. accept: pc<=pc+INST_BYTES. Wraps modulo 2^ADDR_W with no flag.
  7. Otherwise pc holds.
- Redirect and exception inputs are ignored in BOOT. exc_req in BOOT is dropped.
- pc changes only on falling edges or on reset. IMEM samples pc on the rising edge.
- Reset asserted mid-stall or with pend_valid=1 discards the pending redirect immediately.

Test Plan:
1. Reset release: reset low→high; then imem_ready=1, stall=0.
   - pc=0x3000 with pc_valid=0 for one edge.
   - Then 0x3000, 0x3004, 0x3008 on successive falling edges.
2. Stall, then ready low:
   - At pc=0x3008, stall=1 for 3 cycles: pc holds 0x3008.
   - Then imem_ready=0 for 2 cycles: pc still holds.
   - Then the next accept gives 0x300C.
3. Redirect during stall:
   - At pc=0x3010, stall=1 and redir_valid with target 0x3100; pend_valid=1, pc=0x3010.
   - A second redirect to 0x3200 during the same stall overwrites the pending target.
   - Stall release: pc=0x3200, pend_valid=0, then 0x3204.
4. Exception priority: exc_req and redir_valid (0x3300) on the same edge while stall=1.
   - pc=0x4180, pend_valid=0.
5. Misaligned redirect: redir_valid with target 0x3302.
   - pc=0x4180, misalign_err high for exactly one cycle, bad_addr=0x3302.
6. Wrap and async reset:
   - From pc=0xFFFF_FFFC with an accept: pc=0x0000_0000.
   - Assert reset between edges while pend_valid=1: pc=0x3000 and pend_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch program counter with exception/redirect selection, a one-entry
// pending-redirect buffer for redirects that arrive during a stall, and an IMEM handshake.
module pc_fetch_ctrl #(
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]        EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned              INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              exc_req,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              pend_valid,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] bad_addr
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] pend_target;
  logic              misaligned;
  logic              accept;

  assign misaligned = |(redir_target & ALIGN_MASK);
  assign accept     = pc_valid & imem_ready & ~stall;

  // Everything advances on the falling edge so IMEM sees a stable pc at the
  // following rising edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
      misalign_err <= 1'b0;
      bad_addr     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the
      // default below makes misalign_err a single-edge pulse unless re-set.
      misalign_err <= 1'b0;
      if (state == BOOT) begin
        // Redirects and exceptions arriving here are intentionally dropped.
        state    <= RUN;
        pc_valid <= 1'b1;
      end else begin
        if (exc_req) begin
          pc         <= EXC_VECTOR;
          pend_valid <= 1'b0;
        end else if (redir_valid && misaligned) begin
          pc           <= EXC_VECTOR;
          bad_addr     <= redir_target;
          misalign_err <= 1'b1;
          pend_valid   <= 1'b0;
        end else if (redir_valid && !stall) begin
          // Taken immediately; a buffered older redirect is superseded.
          pc         <= redir_target;
          pend_valid <= 1'b0;
        end else if (redir_valid) begin
          pend_target <= redir_target;
          pend_valid  <= 1'b1;
        end else if (pend_valid && !stall) begin
          pc         <= pend_target;
          pend_valid <= 1'b0;
        end else if (accept) begin
          pc <= pc + PC_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs change just after a falling edge,
// outputs are sampled 1 time unit after the following falling edge.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pend_valid;
  logic        misalign_err;
  logic [31:0] bad_addr;

  int vectors;
  int miscompares;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .exc_req      (exc_req),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pend_valid   (pend_valid),
    .misalign_err (misalign_err),
    .bad_addr     (bad_addr)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    exc_req      = 1'b0;
    imem_ready   = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    tick();
    vectors++;
    if (pc !== 32'h0000_3000) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_3000); end
    vectors++;
    if (pc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pc_valid: got %b want 0", pc_valid); end
    vectors++;
    if (pend_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pend_valid: got %b want 0", pend_valid); end
    vectors++;
    if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign_err: got %b want 0", misalign_err); end
    vectors++;
    if (bad_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bad_addr: got %h want 0", bad_addr); end
    reset = 1'b1;
    #1;
    vectors++;
    if (pc_valid !== 1'b0) begin miscompares++; $display("FAIL boot_pc_valid: got %b want 0", pc_valid); end
    tick();
    vectors++;
    if (pc !== 32'h0000_3000 || pc_valid !== 1'b1) begin
      miscompares++; $display("FAIL boot_exit: got pc=%h valid=%b want pc=00003000 valid=1", pc, pc_valid);
    end
    tick();
    vectors++;
    if (pc !== 32'h0000_3004) begin miscompares++; $display("FAIL seq_1: got %h want 00003004", pc); end
    tick();
    vectors++;
    if (pc !== 32'h0000_3008) begin miscompares++; $display("FAIL seq_2: got %h want 00003008", pc); end
  endtask

  task automatic test_stall_ready;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc !== 32'h0000_3008) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h want 00003008", i, pc); end
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc !== 32'h0000_3008) begin miscompares++; $display("FAIL notready_hold[%0d]: got %h want 00003008", i, pc); end
    end
    imem_ready = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h0000_300C) begin miscompares++; $display("FAIL accept_after_hold: got %h want 0000300c", pc); end
    tick();
    vectors++;
    if (pc !== 32'h0000_3010) begin miscompares++; $display("FAIL accept_next: got %h want 00003010", pc); end
  endtask

  task automatic test_redirect_stall;
    stall        = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_3100;
    tick();
    vectors++;
    if (pend_valid !== 1'b1 || pc !== 32'h0000_3010) begin
      miscompares++; $display("FAIL pend_first: got pend=%b pc=%h want pend=1 pc=00003010", pend_valid, pc);
    end
    redir_target = 32'h0000_3200;
    tick();
    vectors++;
    if (pend_valid !== 1'b1 || pc !== 32'h0000_3010) begin
      miscompares++; $display("FAIL pend_overwrite: got pend=%b pc=%h want pend=1 pc=00003010", pend_valid, pc);
    end
    redir_valid = 1'b0;
    stall       = 1'b0;
    tick();
    vectors++;
    if (pc !== 32'h0000_3200 || pend_valid !== 1'b0) begin
      miscompares++; $display("FAIL pend_release: got pc=%h pend=%b want pc=00003200 pend=0", pc, pend_valid);
    end
    tick();
    vectors++;
    if (pc !== 32'h0000_3204) begin miscompares++; $display("FAIL after_pend: got %h want 00003204", pc); end
  endtask

  task automatic test_exception;
    stall        = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_3500;
    tick();
    vectors++;
    if (pend_valid !== 1'b1) begin miscompares++; $display("FAIL exc_setup_pend: got %b want 1", pend_valid); end
    exc_req      = 1'b1;
    redir_target = 32'h0000_3300;
    tick();
    vectors++;
    if (pc !== 32'h0000_4180 || pend_valid !== 1'b0) begin
      miscompares++; $display("FAIL exc_priority: got pc=%h pend=%b want pc=00004180 pend=0", pc, pend_valid);
    end
    idle_inputs();
    tick();
    vectors++;
    if (pc !== 32'h0000_4184) begin miscompares++; $display("FAIL exc_then_seq: got %h want 00004184", pc); end
  endtask

  task automatic test_misalign;
    stall        = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_3302;
    tick();
    vectors++;
    if (pc !== 32'h0000_4180 || misalign_err !== 1'b1 || bad_addr !== 32'h0000_3302) begin
      miscompares++;
      $display("FAIL misalign_take: got pc=%h err=%b bad=%h want pc=00004180 err=1 bad=00003302", pc, misalign_err, bad_addr);
    end
    idle_inputs();
    tick();
    vectors++;
    if (misalign_err !== 1'b0 || bad_addr !== 32'h0000_3302 || pc !== 32'h0000_4184) begin
      miscompares++;
      $display("FAIL misalign_pulse_end: got err=%b bad=%h pc=%h want err=0 bad=00003302 pc=00004184", misalign_err, bad_addr, pc);
    end
  endtask

  task automatic test_back_to_back;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_7000;
    imem_ready   = 1'b0;
    tick();
    vectors++;
    if (pc !== 32'h0000_7000) begin miscompares++; $display("FAIL b2b_first: got %h want 00007000", pc); end
    redir_target = 32'h0000_7100;
    tick();
    vectors++;
    if (pc !== 32'h0000_7100) begin miscompares++; $display("FAIL b2b_second: got %h want 00007100", pc); end
    idle_inputs();
    tick();
    vectors++;
    if (pc !== 32'h0000_7104) begin miscompares++; $display("FAIL b2b_seq: got %h want 00007104", pc); end
  endtask

  task automatic test_wrap_reset;
    redir_valid  = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    tick();
    vectors++;
    if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup: got %h want fffffffc", pc); end
    idle_inputs();
    tick();
    vectors++;
    if (pc !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap: got %h want 00000000", pc); end
    stall        = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_5000;
    tick();
    vectors++;
    if (pend_valid !== 1'b1) begin miscompares++; $display("FAIL rst_setup_pend: got %b want 1", pend_valid); end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (pc !== 32'h0000_3000 || pend_valid !== 1'b0 || pc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got pc=%h pend=%b valid=%b want pc=00003000 pend=0 valid=0", pc, pend_valid, pc_valid);
    end
  endtask

  task automatic test_boot_ignore;
    #2;
    stall        = 1'b0;
    exc_req      = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 32'h0000_6000;
    imem_ready   = 1'b1;
    reset        = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h0000_3000 || pc_valid !== 1'b1 || pend_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_ignore: got pc=%h valid=%b pend=%b want pc=00003000 valid=1 pend=0", pc, pc_valid, pend_valid);
    end
    idle_inputs();
    tick();
    vectors++;
    if (pc !== 32'h0000_3004) begin miscompares++; $display("FAIL boot_ignore_seq: got %h want 00003004", pc); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stall_ready();
    test_redirect_stall();
    test_exception();
    test_misalign();
    test_back_to_back();
    test_wrap_reset();
    test_boot_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
